pulse_stretch: RTL and testbench

- Converse of the team's oneshot edge-to-pulse block: widens a single-cycle `shot` pulse into a level of programmable length.
- Used where a one-cycle event must drive slow consumers such as LEDs, 7-segment blank or enable, or handshake requests.
- Control is a 3-state FSM (IDLE/HOLD/GAP) with a down-counter, retrigger mode and an enforced low guard gap between outputs.

---
 rtl/pulse_stretch_pkg.sv | 13 +
 rtl/load_down_counter.sv | 37 +++
 rtl/pulse_stretch.sv | 118 +++++++++++
 tb/tb_pulse_stretch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and default sizing.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam int DEFAULT_CW  = 8;
    localparam int DEFAULT_GAP = 2;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module load_down_counter
    import pulse_stretch_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle shot into a level of programmable length, followed by a
// forced-low guard gap; supports retrigger during the hold.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int CW  = DEFAULT_CW,
    parameter int GAP = DEFAULT_GAP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shot,
    input  logic [CW-1:0] len,
    input  logic          retrig,
    output logic          level,
    output logic          busy,
    output logic          done,
    output logic          missed
);

    localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_e        state_q, state_d;
    logic          level_q, level_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          missed_q, missed_d;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [CW-1:0] len_load;

    // len==0 behaves as len==1, so both load a count of zero.
    assign len_load = (len == '0) ? '0 : (len - CW'(1));

    load_down_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = len_load;
        cnt_dec  = 1'b0;
        done_d   = 1'b0;
        missed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (shot) begin
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                end
            end
            ST_HOLD: begin
                // A retrigger takes priority over expiry on the final hold cycle.
                if (shot && retrig) begin
                    cnt_load = 1'b1;
                end else begin
                    missed_d = shot;
                    if (cnt_zero) begin
                        done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d  = ST_GAP;
                            cnt_load = 1'b1;
                            cnt_val  = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                missed_d = shot;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
                cnt_val  = '0;
            end
        endcase
        level_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    assign level  = level_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: GAP=2 and GAP=0 builds share one stimulus stream and
// are checked every cycle against a timeline model of the hold and gap windows.
module tb_pulse_stretch;

    logic       clk;
    logic       rst;
    logic       shot;
    logic [7:0] len;
    logic       retrig;
    logic       level_g2, busy_g2, done_g2, missed_g2;
    logic       level_g0, busy_g0, done_g0, missed_g0;

    logic [3:0] exp_q_g2[$];
    logic [3:0] exp_q_g0[$];

    int n_checks;
    int n_fail;
    int cyc;

    pulse_stretch #(.CW(8), .GAP(2)) dut_g2 (
        .clk    (clk),
        .rst    (rst),
        .shot   (shot),
        .len    (len),
        .retrig (retrig),
        .level  (level_g2),
        .busy   (busy_g2),
        .done   (done_g2),
        .missed (missed_g2)
    );

    pulse_stretch #(.CW(8), .GAP(0)) dut_g0 (
        .clk    (clk),
        .rst    (rst),
        .shot   (shot),
        .len    (len),
        .retrig (retrig),
        .level  (level_g0),
        .busy   (busy_g0),
        .done   (done_g0),
        .missed (missed_g0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got {level,busy,done,missed}=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each build is described by the last cycle the level is high (hold_end)
    // and the last cycle busy is high (gap_end), counted in clock edges.
    task automatic model_step(input int t, input int gap, inout int hold_end,
                              inout int gap_end, output logic [3:0] e);
        int   eff_len;
        logic m;
        m = 1'b0;
        eff_len = (len == 8'd0) ? 1 : int'(len);
        if (rst) begin
            hold_end = -1000000;
            gap_end  = -1000000;
            e = 4'b0000;
        end else begin
            if (shot) begin
                if (t - 1 > gap_end) begin
                    hold_end = t + eff_len - 1;
                    gap_end  = hold_end + gap;
                end else if (t - 1 <= hold_end) begin
                    if (retrig) begin
                        hold_end = t + eff_len - 1;
                        gap_end  = hold_end + gap;
                    end else begin
                        m = 1'b1;
                    end
                end else begin
                    m = 1'b1;
                end
            end
            e = {(t <= hold_end), (t <= gap_end), (t == hold_end + 1), m};
        end
    endtask

    initial begin : model
        int         hold_end_g2, gap_end_g2, hold_end_g0, gap_end_g0;
        logic [3:0] e;
        hold_end_g2 = -1000000;
        gap_end_g2  = -1000000;
        hold_end_g0 = -1000000;
        gap_end_g0  = -1000000;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step(cyc, 2, hold_end_g2, gap_end_g2, e);
            exp_q_g2.push_back(e);
            model_step(cyc, 0, hold_end_g0, gap_end_g0, e);
            exp_q_g0.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_g2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL g2_queue cyc=%0d got empty expected entry", cyc);
            end else begin
                check("g2_out", {level_g2, busy_g2, done_g2, missed_g2}, exp_q_g2.pop_front());
            end
            if (exp_q_g0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL g0_queue cyc=%0d got empty expected entry", cyc);
            end else begin
                check("g0_out", {level_g0, busy_g0, done_g0, missed_g0}, exp_q_g0.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic s, input logic [7:0] l, input logic r);
        @(negedge clk);
        shot   = s;
        len    = l;
        retrig = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, len, retrig);
        end
    endtask

    initial begin : stimulus
        logic       s;
        logic [7:0] l;
        logic       r;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        shot     = 1'b0;
        len      = 8'd0;
        retrig   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // basic stretch
        drive(1'b1, 8'd5, 1'b0);
        idle(12);
        // length boundaries
        drive(1'b1, 8'd0, 1'b0);
        idle(6);
        drive(1'b1, 8'd255, 1'b0);
        idle(262);
        // retrigger two cycles in, then on the last hold cycle
        drive(1'b1, 8'd4, 1'b1);
        idle(1);
        drive(1'b1, 8'd6, 1'b1);
        idle(12);
        drive(1'b1, 8'd3, 1'b1);
        idle(2);
        drive(1'b1, 8'd3, 1'b1);
        idle(10);
        // ignored triggers during hold and gap
        drive(1'b1, 8'd4, 1'b0);
        idle(1);
        drive(1'b1, 8'd4, 1'b0);
        idle(2);
        drive(1'b1, 8'd4, 1'b0);
        idle(12);
        // back-to-back: shot on the done cycle
        drive(1'b1, 8'd3, 1'b0);
        idle(3);
        drive(1'b1, 8'd3, 1'b0);
        idle(12);
        // back-to-back: shot one cycle before idle, then on the first idle cycle
        drive(1'b1, 8'd3, 1'b0);
        idle(4);
        drive(1'b1, 8'd3, 1'b0);
        drive(1'b1, 8'd3, 1'b0);
        idle(12);

        // asynchronous reset in the middle of a hold
        drive(1'b1, 8'd10, 1'b0);
        drive(1'b0, 8'd10, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_g2", {level_g2, busy_g2, done_g2, missed_g2}, 4'b0000);
        check("rst_async_g0", {level_g0, busy_g0, done_g0, missed_g0}, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'd5, 1'b0);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
            r = 1'($urandom_range(0, 1));
            drive(s, l, r);
        end
        idle(50);

        @(posedge clk);
        #2;
        n_checks++;
        if ((exp_q_g2.size() != 0) || (exp_q_g0.size() != 0)) begin
            n_fail++;
            $display("FAIL queue_drain got sizes %0d/%0d expected 0/0", exp_q_g2.size(), exp_q_g0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
